// File: rtl/otter_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : otter_instr_encoder_loader
// Description : RV32I instruction encoder and instruction-memory loader for
//               the OTTER core. Decoded field bundles are packed into 32-bit
//               machine words and buffered in a small FIFO. The words are
//               then written to consecutive instruction-memory word addresses
//               through a write/ack handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH   FIFO depth in words (power of two, >= 2)
//   ADDR_W  instruction-memory word-address width
// Ports
//   CLK, RST_N        clock, synchronous active-low reset
//   start, base_addr  start pulse and first word address of a session
//   in_valid/in_ready handshake for one field bundle; in_last ends session
//   in_opcode, in_funct3, in_ir30, in_rd, in_rs1, in_rs2, in_imm
//                     decoded instruction fields
//   mem_we/mem_ack    write request / memory acceptance
//   mem_addr, mem_wdata  registered write address and encoded word
//   busy, done        session active / one-cycle end-of-session pulse
//   err_illegal       sticky unsupported-opcode flag for this session
//   word_count        words written this session
// ============================================================================
module otter_instr_encoder_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic              in_ir30,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W-1:0] word_count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;

  // FIFO storage; pointers carry one extra wrap bit to tell full from empty.
  logic [31:0]    fifo_mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           fifo_empty;
  logic           fifo_full;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        handshake;
  logic        push;
  logic        pop;
  logic        port_free;
  logic        write_done;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign in_ready   = (state == S_RUN) && !fifo_full;
  assign handshake  = in_valid && in_ready;
  assign push       = handshake && enc_legal;
  assign write_done = mem_we && mem_ack;
  // The port can take a new word when idle or when the current one retires.
  assign port_free  = !mem_we || mem_ack;
  // A word pushed this edge is not visible to the pop until the next edge.
  assign pop        = port_free && !fifo_empty;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // --------------------------------------------------------------------------
  // Field packing. Immediate bits outside each format are simply dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    enc_word  = 32'h0000_0000;
    enc_legal = 1'b1;
    case (in_opcode)
      OP_R: begin
        enc_word = {(in_ir30 ? 7'b0100000 : 7'b0000000), in_rs2, in_rs1,
                    in_funct3, in_rd, in_opcode};
      end
      OP_IMM: begin
        // Shift-immediate forms carry the shift amount plus the SRAI bit.
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          enc_word = {1'b0, in_ir30, 5'b00000, in_imm[4:0], in_rs1,
                      in_funct3, in_rd, in_opcode};
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        end
      end
      OP_LOAD: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_JALR: begin
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_opcode};
      end
      OP_STORE: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                    in_opcode};
      end
      OP_BRANCH: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
      end
      OP_JAL: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, in_opcode};
      end
      default: begin
        enc_legal = 1'b0;
      end
    endcase
  end

  // FIFO storage needs no reset: the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
    end
  end

  // --------------------------------------------------------------------------
  // Session control, FIFO pointers and registered write port.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0000_0000;
      err_illegal <= 1'b0;
      word_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (pop) begin
        mem_wdata <= fifo_mem[rd_ptr[PTR_W-1:0]];
        rd_ptr    <= rd_ptr + PTR_ONE;
        mem_we    <= 1'b1;
      end else if (write_done) begin
        mem_we <= 1'b0;
      end

      // Address wraps silently at the top of the address space.
      if (write_done) begin
        word_count <= word_count + ADDR_ONE;
        mem_addr   <= mem_addr + ADDR_ONE;
      end

      case (state)
        S_IDLE: begin
          // The port is idle here, so these loads never race a write.
          if (start) begin
            state       <= S_RUN;
            mem_addr    <= base_addr;
            word_count  <= '0;
            err_illegal <= 1'b0;
          end
        end
        S_RUN: begin
          if (handshake && !enc_legal) begin
            err_illegal <= 1'b1;
          end
          if (handshake && in_last) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty && port_free) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_instr_encoder_loader
// Description : Scoreboard bench for otter_instr_encoder_loader. A driver
//               issues field bundles and pushes the expected write into a
//               queue; a monitor retires writes against that queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_instr_encoder_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_ir30 = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        err_illegal;
  logic [13:0] word_count;

  otter_instr_encoder_loader #(.DEPTH(4), .ADDR_W(14)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_ir30(in_ir30),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .busy(busy), .done(done),
    .err_illegal(err_illegal), .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [13:0] next_addr = '0;
  int          exp_words = 0;
  bit          err_exp = 1'b0;
  int          ack_mode = 1;   // 0: held low, 1: held high, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference encoding built from the ISA bit positions with plain arithmetic.
  function automatic logic [31:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic ir30, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm, output bit legal);
    logic [31:0] base;
    logic [31:0] w;
    legal = 1'b1;
    base  = (32'(rd) << 7) | 32'(op);
    w     = 32'h0;
    case (op)
      7'h33: w = base | (32'(ir30) << 30) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5)
          w = base | (32'(ir30) << 30) | ((imm % 32) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        else
          w = base | ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
      end
      7'h03: w = base | ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
      7'h67: w = base | ((imm & 32'hFFF) << 20) | (32'(rs1) << 15);
      7'h23: w = 32'(op) | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                 | (32'(f3) << 12) | ((imm & 32'h1F) << 7);
      7'h63: w = 32'(op) | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                 | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                 | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
      7'h37, 7'h17: w = base | (imm & 32'hFFFF_F000);
      7'h6F: w = base | (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                 | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
      default: legal = 1'b0;
    endcase
    return w;
  endfunction

  // Present one bundle, wait (bounded) for the handshake, then record the
  // expected memory write if the bundle produces a word.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic ir30,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last, input bit has_word,
                      input logic [31:0] word);
    bit accepted = 1'b0;
    bit rdy;
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_ir30 = ir30;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    for (int n = 0; n < 500 && !accepted; n++) begin
      @(negedge CLK);
      rdy = in_ready;
      @(posedge CLK);
      if (rdy) begin
        accepted = 1'b1;
        if (has_word) begin
          exp_q.push_back('{next_addr, word});
          next_addr = next_addr + 14'd1;
          exp_words++;
        end
      end
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: got no in_ready, expected acceptance");
    end
  endtask

  task automatic send_m(input logic [6:0] op, input logic [2:0] f3, input logic ir30,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
    bit legal;
    logic [31:0] w;
    w = model(op, f3, ir30, rd, rs1, rs2, imm, legal);
    if (!legal) err_exp = 1'b1;
    send(op, f3, ir30, rd, rs1, rs2, imm, last, legal, w);
  endtask

  function automatic logic [6:0] legal_op();
    logic [6:0] ops [9];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    return ops[$urandom_range(8)];
  endfunction

  task automatic send_rand(input logic last, input bit allow_illegal);
    logic [6:0] op;
    op = legal_op();
    if (allow_illegal && $urandom_range(7) == 0) op = ($urandom_range(1) == 0) ? 7'h73 : 7'h0F;
    send_m(op, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           $urandom, last);
  endtask

  task automatic start_session(input logic [13:0] base);
    start = 1'b1;
    base_addr = base;
    @(posedge CLK); #1;
    start = 1'b0;
    base_addr = $urandom;
    next_addr = base;
    exp_words = 0;
    err_exp = 1'b0;
    check("start_busy", busy, 1);
    check("start_word_count", word_count, 0);
    check("start_err_clear", err_illegal, 0);
  endtask

  task automatic finish_session();
    bit found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge CLK);
      if (done) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done pulse, expected one");
    end else begin
      check("end_word_count", word_count, exp_words);
      check("end_err_illegal", err_illegal, err_exp);
      check("end_pending_writes", exp_q.size(), 0);
      @(negedge CLK);
      check("done_one_cycle", done, 0);
      check("end_busy", busy, 0);
    end
    @(posedge CLK); #1;
  endtask

  // mem_ack driver
  initial begin
    forever begin
      @(posedge CLK); #1;
      case (ack_mode)
        0:       mem_ack = 1'b0;
        1:       mem_ack = 1'b1;
        default: mem_ack = 1'($urandom);
      endcase
    end
  end

  // Monitor: retire writes against the scoreboard and check hold stability.
  bit          hold_pend = 1'b0;
  logic [13:0] hold_a;
  logic [31:0] hold_d;
  always @(negedge CLK) begin
    wr_t e;
    if (!RST_N) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_we", mem_we, 1);
        check("hold_addr", mem_addr, hold_a);
        check("hold_data", mem_wdata, hold_d);
      end
      if (mem_we && mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
        end
      end
      hold_pend = mem_we && !mem_ack;
      hold_a = mem_addr;
      hold_d = mem_wdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ack_mode = 1;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_illegal, 0);
    check("rst_word_count", word_count, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_in_ready", in_ready, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // add / sub
    start_session(14'h010);
    send(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b1, 32'h002081B3);
    send(7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 1'b1, 32'h402081B3);
    finish_session();

    // mixed formats; unused fields carry junk that must be ignored
    start_session(14'h100);
    send(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd17, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFF00093);
    send(7'h13, 3'd5, 1'b1, 5'd1, 5'd1, 5'd9,  32'h00000003, 1'b0, 1'b1, 32'h4030D093);
    send(7'h23, 3'd2, 1'b1, 5'd31, 5'd1, 5'd2, 32'h00000008, 1'b0, 1'b1, 32'h0020A423);
    send(7'h63, 3'd0, 1'b0, 5'd31, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFE208EE3);
    send(7'h6F, 3'd7, 1'b1, 5'd1, 5'd7, 5'd9,  32'h00000008, 1'b0, 1'b1, 32'h008000EF);
    send(7'h37, 3'd6, 1'b0, 5'd5, 5'd3, 5'd4,  32'h12345000, 1'b1, 1'b1, 32'h123452B7);
    finish_session();

    // backpressure: 4 in FIFO plus 1 held on the port
    ack_mode = 0;
    start_session(14'h020);
    for (int i = 0; i < 5; i++) send_rand(1'b0, 1'b0);
    in_valid = 1'b1;
    in_opcode = 7'h33;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_in_ready", in_ready, 0);
      check("bp_mem_we", mem_we, 1);
      check("bp_mem_addr", mem_addr, 14'h020);
    end
    in_valid = 1'b0;
    @(posedge CLK); #1;
    ack_mode = 1;
    send_rand(1'b1, 1'b0);
    finish_session();

    // illegal opcode between two legal bundles
    start_session(14'h040);
    send_rand(1'b0, 1'b0);
    send_m(7'h73, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
    send_rand(1'b1, 1'b0);
    check("illegal_exp_words", exp_words, 2);
    finish_session();

    // address wrap at the top of the space
    start_session(14'h3FFF);
    send_rand(1'b0, 1'b0);
    send_rand(1'b1, 1'b0);
    finish_session();

    // reset during DRAIN with a write pending
    ack_mode = 0;
    start_session(14'h050);
    send_rand(1'b0, 1'b0);
    send_rand(1'b1, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check("pre_rst_mem_we", mem_we, 1);
    check("pre_rst_busy", busy, 1);
    RST_N = 1'b0;
    exp_q.delete();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_word_count", word_count, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    ack_mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("post_rst_done", done, 0);
      check("post_rst_mem_we", mem_we, 0);
    end
    @(posedge CLK); #1;

    // randomized sessions with random ack and ignored start pulses
    ack_mode = 2;
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(3, 10);
      start_session(14'($urandom));
      for (int i = 0; i < n; i++) begin
        if (i == 1) begin
          start = 1'b1;
          base_addr = 14'($urandom);
          @(posedge CLK); #1;
          start = 1'b0;
        end
        send_rand(i == n - 1, 1'b1);
      end
      finish_session();
    end
    ack_mode = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
